// File: rtl/cfg_chain_loader.sv
// Configuration-chain writer: accepts words on a valid/ready stream and shifts them
// element 0 first onto the fabric chain head. Optional CRC-16-CCITT output under CFG_CRC_EN.
module cfg_chain_loader #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic              C,
  input  logic              RN,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [0:WORD_W-1] word_data,
  output logic              word_ready,
  output logic              cfg_dout,
  output logic              cfg_shift,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt
`ifdef CFG_CRC_EN
  ,
  output logic [0:15]       crc
`endif
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [0:WORD_W-1] hold;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_nxt;
  logic              last_bit;
  logic              final_bit;
  logic              more_needed;
  logic              xfer;
  logic              clear;

  assign bit_nxt     = bit_cnt + BW'(1);
  assign last_bit    = cfg_shift && (bit_cnt == BW'(WORD_W - 1));
  assign final_bit   = last_bit && (word_cnt == CNT_W'(NUM_WORDS - 1));
  // The word currently on the wire counts as pending until its last bit completes.
  assign more_needed = (int'(word_cnt) + int'(cfg_shift)) < NUM_WORDS;
  assign xfer        = word_valid && word_ready && !abort;
  assign clear       = start && !abort && (state == IDLE || state == DONE);
  assign busy        = (state == SHIFT);
  assign done        = (state == DONE);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        word_ready = (!cfg_shift || last_bit) && more_needed;
        if (abort)          state_nxt = IDLE;
        else if (final_bit) state_nxt = DONE;
      end
      DONE: begin
        if (abort)      state_nxt = IDLE;
        else if (start) state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      hold      <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      cfg_dout  <= 1'b0;
      cfg_shift <= 1'b0;
    end else if (abort && state != IDLE) begin
      hold      <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      cfg_dout  <= 1'b0;
      cfg_shift <= 1'b0;
    end else if (clear) begin
      bit_cnt   <= '0;
      word_cnt  <= '0;
      cfg_shift <= 1'b0;
    end else begin
      // A word accepted on the last-bit cycle reloads directly, so no bubble appears.
      if (xfer) begin
        hold      <= word_data;
        cfg_dout  <= word_data[0];
        cfg_shift <= 1'b1;
        bit_cnt   <= '0;
      end else if (last_bit) begin
        cfg_shift <= 1'b0;
      end else if (cfg_shift) begin
        bit_cnt  <= bit_nxt;
        cfg_dout <= hold[bit_nxt];
      end
      if (last_bit) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef CFG_CRC_EN
  logic [15:0] crc_r;
  logic        crc_fb;

  assign crc_fb = crc_r[15] ^ cfg_dout;
  assign crc    = crc_r;

  always_ff @(posedge C or negedge RN) begin
    if (!RN)                                crc_r <= '1;
    else if ((abort && state != IDLE) || clear) crc_r <= '1;
    else if (cfg_shift)                     crc_r <= {crc_r[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomised self-checking bench for cfg_chain_loader; the expected serial stream
// and CRC are computed from the word list, independent of the loader's internals.
module tb_cfg_chain_loader;
  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 8;
  localparam int NBITS     = WORD_W * NUM_WORDS;

  logic              C = 1'b0;
  logic              RN = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              word_valid = 1'b0;
  logic [0:WORD_W-1] word_data = '0;
  logic              word_ready, cfg_dout, cfg_shift, busy, done;
  logic [3:0]        word_cnt;
`ifdef CFG_CRC_EN
  logic [0:15]       crc;
`endif

  cfg_chain_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .C(C), .RN(RN), .start(start), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .cfg_dout(cfg_dout),
    .cfg_shift(cfg_shift), .busy(busy), .done(done), .word_cnt(word_cnt)
`ifdef CFG_CRC_EN
    , .crc(crc)
`endif
  );

  always #5 C = ~C;

  int vectors = 0;
  int miscompares = 0;

  logic [0:WORD_W-1] words[NUM_WORDS];
  bit got[$];
  int shift_cnt, bubbles, holds_bad, last_shift, done_cyc;

  function automatic void fill_words(input bit pattern);
    for (int i = 0; i < NUM_WORDS; i++)
      words[i] = pattern ? 16'hA5C3 + 16'(i * 'h1111) : 16'($urandom);
  endfunction

  function automatic int stream_errs();
    int e = 0;
    if (got.size() != NBITS) return NBITS;
    for (int i = 0; i < NUM_WORDS; i++)
      for (int k = 0; k < WORD_W; k++)
        if (got[i*WORD_W + k] != words[i][k]) e++;
    return e;
  endfunction

  function automatic logic [15:0] crc_model();
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < NUM_WORDS; i++)
      for (int k = 0; k < WORD_W; k++) begin
        bit fb = c[15] ^ words[i][k];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  // Drives one load cycle by cycle from negedge to negedge, recording the serial output.
  task automatic run_load(input bit do_start, input int gap_word, input int abort_word,
                          input int start_mid, input int stop_bits);
    int wi = 0, cyc = 0, gap_left = 0, post = 0;
    bit finished = 0, prev_dout = 0, acc;
    shift_cnt = 0; bubbles = 0; holds_bad = 0; last_shift = -1; done_cyc = -1;
    got.delete();
    if (do_start) begin
      @(negedge C); start = 1; word_valid = 0;
      @(negedge C); start = 0;
    end
    while (cyc < 600) begin
      if (cfg_shift) begin
        got.push_back(cfg_dout); shift_cnt++; last_shift = cyc;
      end else if (shift_cnt > 0 && !done) begin
        bubbles++;
        if (cfg_dout !== prev_dout) holds_bad++;
      end
      prev_dout = cfg_dout;
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        post++;
        if (post > 3) begin finished = 1; break; end
      end
      if (stop_bits > 0 && shift_cnt == stop_bits) begin finished = 1; break; end
      start = (cyc == start_mid);
      word_valid = (wi < NUM_WORDS) && (gap_left == 0);
      if (gap_left > 0) gap_left--;
      if (wi < NUM_WORDS) word_data = words[wi];
      if (wi == abort_word && word_ready && word_valid) abort = 1;
      acc = word_valid && word_ready && !abort;
      if (acc) begin
        if (wi == gap_word) gap_left = 18;
        wi++;
      end
      @(negedge C);
      cyc++;
      if (abort) begin abort = 0; finished = 1; break; end
    end
    start = 0;
    word_valid = 0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL load_timeout: got no completion after %0d cycles, expected completion", cyc);
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL rst_word_ready: got %b expected 0", word_ready); end
    vectors++; if (cfg_dout !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_dout: got %b expected 0", cfg_dout); end
    vectors++; if (cfg_shift !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_shift: got %b expected 0", cfg_shift); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    vectors++; if (word_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); end
    @(negedge C); RN = 1;
    @(negedge C);
  endtask

  task automatic check_full_load(input string tag, input int exp_bubbles);
    int e = stream_errs();
    vectors++; if (shift_cnt != NBITS) begin miscompares++; $display("FAIL %s_shift_count: got %0d expected %0d", tag, shift_cnt, NBITS); end
    vectors++; if (bubbles != exp_bubbles) begin miscompares++; $display("FAIL %s_bubbles: got %0d expected %0d", tag, bubbles, exp_bubbles); end
    vectors++; if (holds_bad != 0) begin miscompares++; $display("FAIL %s_dout_hold: got %0d changes expected 0", tag, holds_bad); end
    vectors++; if (e != 0) begin miscompares++; $display("FAIL %s_stream: got %0d bit errors expected 0", tag, e); end
    vectors++; if (done_cyc != last_shift + 1) begin miscompares++; $display("FAIL %s_done_delay: got cycle %0d expected %0d", tag, done_cyc, last_shift + 1); end
    vectors++; if (word_cnt !== 4'd8) begin miscompares++; $display("FAIL %s_word_cnt: got %0d expected 8", tag, word_cnt); end
    vectors++; if (busy !== 1'b0 || word_ready !== 1'b0) begin miscompares++; $display("FAIL %s_idle_flags: got busy=%b ready=%b expected 0 0", tag, busy, word_ready); end
`ifdef CFG_CRC_EN
    vectors++; if (crc !== crc_model()) begin miscompares++; $display("FAIL %s_crc: got %h expected %h", tag, crc, crc_model()); end
`endif
  endtask

  task automatic test_back_to_back();
    fill_words(1);
    run_load(1, -1, -1, -1, 0);
    check_full_load("b2b_pattern", 0);
    fill_words(0);
    run_load(1, -1, -1, -1, 0);
    check_full_load("b2b_random", 0);
  endtask

  task automatic test_starved();
    fill_words(0);
    run_load(1, 2, -1, -1, 0);
    check_full_load("starved", 3);
  endtask

  task automatic test_start_rules();
    @(negedge C); abort = 1;
    @(negedge C); abort = 0;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_from_done: got done=%b busy=%b expected 0 0", done, busy); end
    start = 1; word_valid = 1; word_data = 16'h1234;
    vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL idle_start_ready: got %b expected 0", word_ready); end
    @(negedge C); start = 0; word_valid = 0;
    vectors++; if (busy !== 1'b1 || cfg_shift !== 1'b0) begin miscompares++; $display("FAIL idle_start_no_xfer: got busy=%b shift=%b expected 1 0", busy, cfg_shift); end
`ifdef CFG_CRC_EN
    vectors++; if (crc !== 16'hFFFF) begin miscompares++; $display("FAIL crc_init: got %h expected ffff", crc); end
`endif
    fill_words(0);
    run_load(0, -1, -1, 40, 0);
    check_full_load("start_while_busy", 0);
    @(negedge C); start = 1;
    @(negedge C); start = 0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0 || word_cnt !== 4'd0) begin miscompares++; $display("FAIL restart_from_done: got busy=%b done=%b cnt=%0d expected 1 0 0", busy, done, word_cnt); end
    fill_words(0);
    run_load(0, -1, -1, -1, 0);
    check_full_load("restart", 0);
  endtask

  task automatic test_abort();
    int extra = 0;
    fill_words(0);
    run_load(1, -1, 4, -1, 0);
    vectors++; if (shift_cnt != 64) begin miscompares++; $display("FAIL abort_bits: got %0d expected 64", shift_cnt); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_state: got busy=%b done=%b expected 0 0", busy, done); end
    vectors++; if (word_cnt !== 4'd0 || word_ready !== 1'b0) begin miscompares++; $display("FAIL abort_cnt_ready: got cnt=%0d ready=%b expected 0 0", word_cnt, word_ready); end
    vectors++; if (cfg_shift !== 1'b0 || cfg_dout !== 1'b0) begin miscompares++; $display("FAIL abort_outputs: got shift=%b dout=%b expected 0 0", cfg_shift, cfg_dout); end
`ifdef CFG_CRC_EN
    vectors++; if (crc !== 16'hFFFF) begin miscompares++; $display("FAIL abort_crc: got %h expected ffff", crc); end
`endif
    word_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      if (cfg_shift) extra++;
    end
    word_valid = 0;
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL abort_extra_shift: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    fill_words(0);
    run_load(1, -1, -1, -1, 5);
    vectors++; if (shift_cnt != 5 || busy !== 1'b1) begin miscompares++; $display("FAIL midload_setup: got bits=%0d busy=%b expected 5 1", shift_cnt, busy); end
    #2 RN = 0;
    #1;
    vectors++; if ({word_ready, cfg_dout, cfg_shift, busy, done} !== 5'b0 || word_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL midload_reset: got ready=%b dout=%b shift=%b busy=%b done=%b cnt=%0d expected all 0",
               word_ready, cfg_dout, cfg_shift, busy, done, word_cnt);
    end
    @(negedge C); RN = 1;
    @(negedge C);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midload_idle: got busy=%b expected 0", busy); end
    start = 1;
    @(negedge C); start = 0;
    vectors++; if (word_cnt !== 4'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL midload_fresh: got cnt=%0d busy=%b expected 0 1", word_cnt, busy); end
    fill_words(0);
    run_load(0, -1, -1, -1, 0);
    check_full_load("after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_starved();
    test_start_rules();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of run, expected $finish");
    $fatal(1);
  end
endmodule
